// File: rtl/dcache_dm_param.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Line refills and write-throughs use a req/ack memory handshake.
module dcache_dm_param #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int LINES  = 8,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CSN,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] DI,
    output logic [DATA_W-1:0] DOUT,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int IDX_W = $clog2(LINES);
    localparam int OFF_W = $clog2(WORDS);
    localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REFILL = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]        state;
    logic [OFF_W-1:0]  beat;
    logic              hit_q;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_ram  [LINES];
    logic [DATA_W-1:0] data_ram [LINES*WORDS];

    logic [OFF_W-1:0] off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit;
    logic             rd_req;
    logic             wr_req;
    logic             ack;
    logic [1:0]       unused_addr;

    assign off    = ADDR[OFF_W+1:2];
    assign idx    = ADDR[OFF_W+IDX_W+1:OFF_W+2];
    assign tag    = ADDR[ADDR_W-1:OFF_W+IDX_W+2];
    assign hit    = valid[idx] & (tag_ram[idx] == tag);
    assign rd_req = ~CSN & WEN;
    assign wr_req = ~CSN & ~WEN;
    assign ack    = mem_req & mem_ack;

    assign unused_addr = ADDR[1:0];

    assign mem_req   = (state == REFILL) | (state == WRITE);
    assign mem_wen   = (state != WRITE);
    assign mem_wdata = (state == WRITE) ? DI : '0;
    assign stall     = mem_req | ((state == IDLE) & ~CSN & (~WEN | ~hit));

    always_comb begin
        mem_addr = '0;
        if (state == REFILL)
            mem_addr = {ADDR[ADDR_W-1:OFF_W+2], beat, 2'b00};
        else if (state == WRITE)
            mem_addr = {ADDR[ADDR_W-1:2], 2'b00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat     <= '0;
            hit_q    <= 1'b0;
            valid    <= '0;
            DOUT     <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rd_req && hit) begin
                        DOUT <= data_ram[{idx, off}];
                        if (~&hit_cnt)
                            hit_cnt <= hit_cnt + CNT_W'(1);
                    end else if (rd_req) begin
                        valid[idx] <= 1'b0;
                        beat       <= '0;
                        state      <= REFILL;
                        if (~&miss_cnt)
                            miss_cnt <= miss_cnt + CNT_W'(1);
                    end else if (wr_req) begin
                        hit_q <= hit;
                        state <= WRITE;
                    end
                end
                REFILL: begin
                    if (ack) begin
                        beat <= beat + OFF_W'(1);
                        if (&beat) begin
                            valid[idx] <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (ack)
                        state <= DONE;
                end
                DONE: begin
                    // request is still held; retire it without re-lookup
                    if (WEN)
                        DOUT <= data_ram[{idx, off}];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && ack) begin
            data_ram[{idx, beat}] <= mem_rdata;
            if (&beat)
                tag_ram[idx] <= tag;
        end
        if (state == WRITE && ack && hit_q)
            data_ram[{idx, off}] <= DI;
    end

endmodule

// File: tb/tb_dcache_dm_param.sv
// Directed bench for dcache_dm_param against a simple memory model.
// A second CNT_W=2 instance exercises counter saturation.
module tb_dcache_dm_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        CSN, WEN;
    logic [11:0] ADDR;
    logic [31:0] DI, DOUT;
    logic        stall;
    logic        mem_req, mem_wen, mem_ack;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] hit_cnt, miss_cnt;

    logic        s_csn, s_wen, s_stall, s_req, s_mwen;
    logic [11:0] s_addr, s_maddr;
    logic [31:0] s_di, s_dout, s_wdata, s_rdata;
    logic [1:0]  s_hit, s_miss;

    int nvec = 0;
    int nerr = 0;
    int lat  = 0;
    int wcnt;
    int rd_n = 0;
    int wr_n = 0;
    bit inited;
    logic [11:0] rd_log [64];
    logic [11:0] wr_last;
    logic [31:0] mem [1024];

    always #5 clk = ~clk;

    dcache_dm_param u_dut (
        .clk(clk), .rst(rst), .CSN(CSN), .WEN(WEN), .ADDR(ADDR),
        .DI(DI), .DOUT(DOUT), .stall(stall), .mem_req(mem_req),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    dcache_dm_param #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .CSN(s_csn), .WEN(s_wen), .ADDR(s_addr),
        .DI(s_di), .DOUT(s_dout), .stall(s_stall), .mem_req(s_req),
        .mem_wen(s_mwen), .mem_addr(s_maddr), .mem_wdata(s_wdata),
        .mem_rdata(s_rdata), .mem_ack(s_req),
        .hit_cnt(s_hit), .miss_cnt(s_miss)
    );

    assign s_rdata   = {20'h0, s_maddr} ^ 32'hA5A5_0000;
    assign mem_ack   = mem_req && (wcnt == lat);
    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= 0;
            if (!inited) begin
                for (int i = 0; i < 1024; i++)
                    mem[i] <= {20'h0, i[9:0], 2'b00} ^ 32'hA5A5_0000;
                inited <= 1'b1;
            end
        end else if (mem_req) begin
            if (mem_ack) begin
                wcnt <= 0;
                if (!mem_wen) begin
                    mem[mem_addr[11:2]] <= mem_wdata;
                    wr_n    <= wr_n + 1;
                    wr_last <= mem_addr;
                end else begin
                    if (rd_n < 64)
                        rd_log[rd_n] <= mem_addr;
                    rd_n <= rd_n + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    task automatic check(input string t, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", t, got, exp);
        end
    endtask

    task automatic rd(input string t, input logic [11:0] a,
                      input logic [31:0] exp, input int exp_st);
        int n = 0;
        CSN = 1'b0; WEN = 1'b1; ADDR = a;
        #1;
        while (stall && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({t, "_stall"}, n, exp_st);
        @(posedge clk); #1;
        CSN = 1'b1;
        check({t, "_dout"}, DOUT, exp);
    endtask

    task automatic wr(input string t, input logic [11:0] a,
                      input logic [31:0] d);
        int n = 0;
        int w0 = wr_n;
        int r0 = rd_n;
        CSN = 1'b0; WEN = 1'b0; ADDR = a; DI = d;
        #1;
        while (stall && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check({t, "_stall"}, n, 2);
        @(posedge clk); #1;
        CSN = 1'b1; WEN = 1'b1;
        check({t, "_nwr"}, wr_n - w0, 1);
        check({t, "_waddr"}, {20'h0, wr_last}, {20'h0, a});
        check({t, "_nrd"}, rd_n - r0, 0);
    endtask

    task automatic beats(input string t, input int b0,
                         input logic [11:0] base);
        check({t, "_nbeat"}, rd_n - b0, 4);
        for (int k = 0; k < 4; k++)
            check({t, "_beat"}, {20'h0, rd_log[b0+k]},
                  {20'h0, base + 12'(4*k)});
    endtask

    initial begin
        int b0;
        int n;
        rst = 1'b1; CSN = 1'b1; WEN = 1'b1; ADDR = '0; DI = '0;
        s_csn = 1'b1; s_wen = 1'b1; s_addr = '0; s_di = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", {31'h0, stall}, 0);
        check("rst_req", {31'h0, mem_req}, 0);
        check("rst_wen", {31'h0, mem_wen}, 1);
        check("rst_dout", DOUT, 0);
        check("rst_hit", {16'h0, hit_cnt}, 0);
        check("rst_miss", {16'h0, miss_cnt}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        b0 = rd_n;
        rd("miss40", 12'h040, 32'hA5A5_0040, 5);
        beats("miss40", b0, 12'h040);
        check("miss_cnt1", {16'h0, miss_cnt}, 1);

        rd("hit48", 12'h048, 32'hA5A5_0048, 0);
        check("hit_cnt1", {16'h0, hit_cnt}, 1);

        lat = 3;
        rd("miss20_l3", 12'h020, 32'hA5A5_0020, 17);
        lat = 0;
        check("miss_cnt2", {16'h0, miss_cnt}, 2);

        wr("wrhit44", 12'h044, 32'hDEAD_BEEF);
        rd("hit44", 12'h044, 32'hDEAD_BEEF, 0);
        check("hit_cnt2", {16'h0, hit_cnt}, 2);

        wr("wrmiss3f0", 12'h3F0, 32'hDEAD_BEEF);
        rd("hit40", 12'h040, 32'hA5A5_0040, 0);
        check("hit_cnt3", {16'h0, hit_cnt}, 3);
        rd("miss3f0", 12'h3F0, 32'hDEAD_BEEF, 5);
        check("miss_cnt3", {16'h0, miss_cnt}, 3);

        b0 = rd_n;
        rd("missC0", 12'h0C0, 32'hA5A5_00C0, 5);
        beats("missC0", b0, 12'h0C0);
        rd("evict40", 12'h040, 32'hA5A5_0040, 5);
        check("miss_cnt5", {16'h0, miss_cnt}, 5);
        rd("hit44b", 12'h044, 32'hDEAD_BEEF, 0);
        check("hit_cnt4", {16'h0, hit_cnt}, 4);

        // abort a refill during its third beat
        lat = 3;
        b0 = rd_n;
        CSN = 1'b0; WEN = 1'b1; ADDR = 12'h0C0;
        n = 0;
        while (rd_n - b0 < 2 && n < 200) begin
            @(posedge clk); n++;
        end
        check("rst_wait", {31'h0, n >= 200}, 0);
        #2;
        check("mid_req", {31'h0, mem_req}, 1);
        rst = 1'b1;
        #1;
        check("abort_req", {31'h0, mem_req}, 0);
        check("abort_hit", {16'h0, hit_cnt}, 0);
        check("abort_miss", {16'h0, miss_cnt}, 0);
        CSN = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        b0 = rd_n;
        rd("post40", 12'h040, 32'hA5A5_0040, 5);
        beats("post40", b0, 12'h040);
        check("post_miss", {16'h0, miss_cnt}, 1);
        rd("postC0", 12'h0C0, 32'hA5A5_00C0, 5);

        // saturating counters on the CNT_W=2 instance
        s_csn = 1'b0; s_wen = 1'b1; s_addr = 12'h040;
        #1;
        n = 0;
        while (s_stall && n < 200) begin
            @(posedge clk); #1; n++;
        end
        check("sat_stall", n, 5);
        @(posedge clk); #1;
        check("sat_dout", s_dout, 32'hA5A5_0040);
        repeat (5) @(posedge clk);
        #1;
        s_csn = 1'b1;
        check("sat_hit", {30'h0, s_hit}, 3);
        check("sat_miss", {30'h0, s_miss}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
